// File: rtl/nn_layer_seq_if.sv
// Streaming bus of the serial neuron layer: bit-serial input handshake and
// the activated-result output handshake.
interface nn_layer_seq_if #(
  parameter int alu_width = 12,
  parameter int idx_width = 2
);
  logic                 nn_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [alu_width-1:0] out_data;
  logic [idx_width-1:0] out_idx;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output nn_in, in_valid, out_ready,
    input  in_ready, out_data, out_idx, out_valid
  );

  modport slave (
    input  nn_in, in_valid, out_ready,
    output in_ready, out_data, out_idx, out_valid
  );
endinterface

// File: rtl/nn_layer_seq.sv
// Time-multiplexed layer of bit-serial neurons: each neuron accumulates
// win_len +/-1 contributions into a saturating aggregator, then emits ReLU(agg).
module nn_layer_seq #(
  parameter int agg_width = 12,
  parameter int alu_width = 12,
  parameter int win_len   = 8,
  parameter int n_neur    = 4,
  localparam int idx_width = (n_neur > 1) ? $clog2(n_neur) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [n_neur-1:0] wsign,
  nn_layer_seq_if.slave     bus,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    ACT,
    OUT,
    DONE
  } state_e;

  localparam logic signed [agg_width-1:0] agg_max  = {1'b0, {(agg_width-1){1'b1}}};
  localparam logic signed [agg_width-1:0] agg_min  = {1'b1, {(agg_width-1){1'b0}}};
  localparam logic        [agg_width-1:0] last_bit = agg_width'(win_len - 1);
  localparam logic        [idx_width-1:0] last_neur = idx_width'(n_neur - 1);

  state_e                       state_q, state_d;
  logic signed [agg_width-1:0]  agg_q, agg_d;
  logic        [agg_width-1:0]  bit_cnt_q, bit_cnt_d;
  logic        [idx_width-1:0]  neur_idx_q, neur_idx_d;
  logic        [alu_width-1:0]  res_q, res_d;
  logic        [alu_width-1:0]  relu;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d    = state_q;
    agg_d      = agg_q;
    bit_cnt_d  = bit_cnt_q;
    neur_idx_d = neur_idx_q;
    res_d      = res_q;
    relu       = '0;
    relu[agg_width-2:0] = agg_q[agg_width-2:0];

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = ACC;
            agg_d      = '0;
            bit_cnt_d  = '0;
            neur_idx_d = '0;
          end
        end
        ACC: begin
          if (bus.in_valid) begin
            // Saturate instead of wrapping at either rail.
            if (bus.nn_in) begin
              if (wsign[neur_idx_q]) begin
                if (agg_q != agg_min) agg_d = agg_q - agg_width'(1);
              end else begin
                if (agg_q != agg_max) agg_d = agg_q + agg_width'(1);
              end
            end
            bit_cnt_d = bit_cnt_q + agg_width'(1);
            if (bit_cnt_q == last_bit) state_d = ACT;
          end
        end
        ACT: begin
          res_d   = agg_q[agg_width-1] ? '0 : relu;
          state_d = OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            if (neur_idx_q == last_neur) begin
              state_d = DONE;
            end else begin
              neur_idx_d = neur_idx_q + idx_width'(1);
              agg_d      = '0;
              bit_cnt_d  = '0;
              state_d    = ACC;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      agg_q      <= '0;
      bit_cnt_q  <= '0;
      neur_idx_q <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      agg_q      <= agg_d;
      bit_cnt_q  <= bit_cnt_d;
      neur_idx_q <= neur_idx_d;
      res_q      <= res_d;
    end
  end

  // Handshake flags decode straight from state, so reset clears them at once.
  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_data  = res_q;
  assign bus.out_idx   = neur_idx_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);

endmodule

// File: tb/tb_nn_layer_seq.sv
// Scoreboard bench for nn_layer_seq: a default-sized layer and a narrow
// saturating layer, with expected results queued as stimulus is issued.
module tb_nn_layer_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       a_start = 1'b0, a_abort = 1'b0, a_busy, a_done;
  logic [3:0] a_wsign = '0;
  logic       b_start = 1'b0, b_abort = 1'b0, b_busy, b_done;
  logic [1:0] b_wsign = '0;

  nn_layer_seq_if #(.alu_width(12), .idx_width(2)) a_if ();
  nn_layer_seq_if #(.alu_width(4),  .idx_width(1)) b_if ();

  nn_layer_seq #(.agg_width(12), .alu_width(12), .win_len(8), .n_neur(4)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .wsign(a_wsign),
    .bus(a_if), .busy(a_busy), .done(a_done)
  );

  nn_layer_seq #(.agg_width(4), .alu_width(4), .win_len(10), .n_neur(2)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .wsign(b_wsign),
    .bus(b_if), .busy(b_busy), .done(b_done)
  );

  typedef struct {
    int idx;
    int data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   checks = 0;
  int   errors = 0;
  int   done_a_cnt = 0;
  int   done_b_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: compare each accepted result against the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_if.out_valid === 1'b1 && a_if.out_ready === 1'b1) begin
        if (q_a.size() == 0) check("a_unexpected_out", 32'd1, 32'd0);
        else begin
          e_a = q_a.pop_front();
          check("a_out_idx",  32'(a_if.out_idx),  e_a.idx);
          check("a_out_data", 32'(a_if.out_data), e_a.data);
        end
      end
      if (a_done === 1'b1) done_a_cnt++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (b_if.out_valid === 1'b1 && b_if.out_ready === 1'b1) begin
        if (q_b.size() == 0) check("b_unexpected_out", 32'd1, 32'd0);
        else begin
          e_b = q_b.pop_front();
          check("b_out_idx",  32'(b_if.out_idx),  e_b.idx);
          check("b_out_data", 32'(b_if.out_data), e_b.data);
        end
      end
      if (b_done === 1'b1) done_b_cnt++;
    end
  end

  // Offer one bit, wait (bounded) until it is accepted, then idle for gap cycles.
  task automatic send_bit(input bit sel, input logic b, input int gap);
    int n = 0;
    if (!sel) begin a_if.nn_in = b; a_if.in_valid = 1'b1; end
    else      begin b_if.nn_in = b; b_if.in_valid = 1'b1; end
    @(negedge clk);
    while (((!sel) ? a_if.in_ready : b_if.in_ready) !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (!sel) a_if.in_valid = 1'b0;
    else      b_if.in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(input bit sel);
    if (!sel) a_start = 1'b1; else b_start = 1'b1;
    @(posedge clk); #1;
    if (!sel) a_start = 1'b0; else b_start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bits0[8];
    int n;
    bits0 = '{1, 0, 1, 1, 0, 1, 1, 1};
    a_if.nn_in = 1'b0; a_if.in_valid = 1'b0; a_if.out_ready = 1'b0;
    b_if.nn_in = 1'b0; b_if.in_valid = 1'b0; b_if.out_ready = 1'b0;

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    check("rst_a_busy",      32'(a_busy),         32'd0);
    check("rst_a_done",      32'(a_done),         32'd0);
    check("rst_a_in_ready",  32'(a_if.in_ready),  32'd0);
    check("rst_a_out_valid", 32'(a_if.out_valid), 32'd0);
    check("rst_a_out_data",  32'(a_if.out_data),  32'd0);
    check("rst_a_out_idx",   32'(a_if.out_idx),   32'd0);
    check("rst_b_busy",      32'(b_busy),         32'd0);
    check("rst_b_out_data",  32'(b_if.out_data),  32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_no_start_busy", 32'(a_busy), 32'd0);
    end
    @(posedge clk); #1;

    // Layer on A: neuron 0 positive, neuron 1 negative weight with gaps.
    a_wsign = 4'b0010;
    q_a.push_back('{0, 6});
    pulse_start(1'b0);
    @(negedge clk);
    check("acc_in_ready", 32'(a_if.in_ready), 32'd1);
    check("acc_busy",     32'(a_busy),        32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send_bit(1'b0, bits0[i][0], 0);
    @(negedge clk);
    check("act_no_valid", 32'(a_if.out_valid), 32'd0);
    @(negedge clk);
    check("out_valid_latency", 32'(a_if.out_valid), 32'd1);

    // Backpressure with input offered: nothing may move.
    a_if.nn_in = 1'b1; a_if.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(a_if.out_valid), 32'd1);
      check("bp_out_data",  32'(a_if.out_data),  32'd6);
      check("bp_out_idx",   32'(a_if.out_idx),   32'd0);
      check("bp_in_ready",  32'(a_if.in_ready),  32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
    a_if.out_ready = 1'b1;

    q_a.push_back('{1, 0});
    a_start = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b1, 2);
    a_start = 1'b0;
    q_a.push_back('{2, 8});
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b1, 0);
    q_a.push_back('{3, 1});
    for (int i = 0; i < 8; i++) send_bit(1'b0, (i == 7) ? 1'b1 : 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    check("last_out_valid", 32'(a_if.out_valid), 32'd1);
    @(negedge clk);
    check("done_pulse", 32'(a_done), 32'd1);
    check("done_busy",  32'(a_busy), 32'd1);
    @(negedge clk);
    check("after_done_done",      32'(a_done),         32'd0);
    check("after_done_busy",      32'(a_busy),         32'd0);
    check("after_done_in_ready",  32'(a_if.in_ready),  32'd0);
    check("after_done_out_valid", 32'(a_if.out_valid), 32'd0);
    @(posedge clk); #1;
    check("done_count", done_a_cnt, 32'd1);
    check("a_queue_empty", 32'(q_a.size()), 32'd0);

    // Abort in ACC with a transfer pending.
    a_wsign = 4'b0000;
    pulse_start(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1, 0);
    a_if.nn_in = 1'b1; a_if.in_valid = 1'b1; a_abort = 1'b1;
    @(posedge clk); #1;
    a_abort = 1'b0; a_if.in_valid = 1'b0;
    check("abort_busy",      32'(a_busy),         32'd0);
    check("abort_in_ready",  32'(a_if.in_ready),  32'd0);
    check("abort_out_valid", 32'(a_if.out_valid), 32'd0);
    repeat (15) @(posedge clk);
    #1;
    check("abort_no_done", done_a_cnt, 32'd1);

    // Reset in the middle of a neuron.
    pulse_start(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1, 0);
    #3 rst = 1'b1;
    #1;
    check("midrst_busy",      32'(a_busy),         32'd0);
    check("midrst_in_ready",  32'(a_if.in_ready),  32'd0);
    check("midrst_out_data",  32'(a_if.out_data),  32'd0);
    check("midrst_out_idx",   32'(a_if.out_idx),   32'd0);
    check("midrst_out_valid", 32'(a_if.out_valid), 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_stay_idle", 32'(a_busy), 32'd0);
    end
    @(posedge clk); #1;

    // Narrow layer on B: saturation at both rails.
    b_wsign = 2'b10;
    b_if.out_ready = 1'b1;
    q_b.push_back('{0, 7});
    q_b.push_back('{1, 0});
    pulse_start(1'b1);
    for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b1, 0);
    n = 0;
    while (b_done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b_done_seen", 32'(b_done), 32'd1);
    @(negedge clk);
    check("b_idle_after_done", 32'(b_busy), 32'd0);
    @(posedge clk); #1;
    check("b_done_count",  done_b_cnt,        32'd1);
    check("b_queue_empty", 32'(q_b.size()),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_layer_seq.md
NN_LAYER_SEQ -- requirements
Module: nn_layer_seq

Interface
REQ-001 SHALL have parameter agg_width, default 12: signed two's-complement aggregator width.
REQ-002 SHALL have parameter alu_width, default 12: output result width; alu_width >= agg_width-1.
REQ-003 SHALL have parameter win_len, default 8: accepted input bits per neuron; legal range 1..2^agg_width-1.
REQ-004 SHALL have parameter n_neur, default 4: neurons time-multiplexed on the shared aggregator/ALU; legal range >= 1.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: begin layer evaluation; sampled in IDLE only.
REQ-008 SHALL have port abort, input, 1: synchronous cancel of the current layer.
REQ-009 SHALL have port wsign, input, n_neur: per-neuron weight sign; 0 = add, 1 = subtract; must be static while busy.
REQ-010 SHALL have port nn_in, input, 1: serial input bit.
REQ-011 SHALL have port in_valid, input, 1: nn_in valid.
REQ-012 SHALL have port in_ready, output, 1: controller accepts nn_in.
REQ-013 SHALL have port out_data, output, alu_width: activated neuron result, unsigned.
REQ-014 SHALL have port out_idx, output, max(1,clog2(n_neur)): neuron index of out_data.
REQ-015 SHALL have port out_valid, output, 1: out_data/out_idx valid.
REQ-016 SHALL have port out_ready, input, 1: downstream accepts result.
REQ-017 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-018 SHALL have port done, output, 1: one-cycle pulse at layer completion.

Function
REQ-019 SHALL implement FSM states IDLE, ACC, ACT, OUT, DONE.
REQ-020 IDLE: start=1 -> ACC; agg, bit_cnt, neur_idx cleared to 0. Otherwise stay in IDLE.
REQ-021 start SHALL be ignored in every state other than IDLE.
REQ-022 in_ready SHALL be 1 only in ACC; an input transfer is an edge with in_valid & in_ready.
REQ-023 On each transfer: agg += nn_in if wsign[neur_idx]=0, else agg -= nn_in; bit_cnt increments; in_valid=0 stalls with no state change.
REQ-024 agg SHALL saturate at +2^(agg_width-1)-1 and -2^(agg_width-1); it SHALL NOT wrap.
REQ-025 The transfer with bit_cnt == win_len-1 SHALL move ACC -> ACT.
REQ-026 ACT lasts exactly one cycle: result register <= 0 if agg < 0, else agg zero-extended to alu_width (ReLU); -> OUT.
REQ-027 out_valid SHALL first be high in the second cycle after the edge that accepted the last bit (ACT one cycle, then OUT).
REQ-028 OUT: out_valid=1; out_data and out_idx held stable until out_valid & out_ready.
REQ-029 OUT handshake with neur_idx < n_neur-1: neur_idx++, agg and bit_cnt cleared, -> ACC.
REQ-030 OUT handshake with neur_idx == n_neur-1 -> DONE; DONE asserts done=1 for exactly one cycle, then -> IDLE.
REQ-031 abort=1 in any non-IDLE state -> IDLE on the next edge; no done pulse, no further out_valid, and any pending transfer in that cycle is discarded. abort has priority over every other event.
REQ-032 out_valid, in_ready, and done SHALL be 0 in IDLE.

Reset
REQ-033 rst=1 SHALL force IDLE immediately, regardless of clk, and clear agg, bit_cnt, neur_idx, out_data, out_idx, out_valid, in_ready, busy, and done to 0.
REQ-034 rst asserted mid-operation SHALL discard all partial results; after release, the block waits in IDLE for start.

Verification
REQ-035 Reset: assert rst mid-clock -> all outputs 0 without a clock edge; after release, start=0 keeps busy=0.
REQ-036 Positive neuron, defaults, wsign=0000: start, then bits 1,0,1,1,0,1,1,1 with in_valid=1 -> out_data=6, out_idx=0, out_valid rising 2 cycles after the 8th accept.
REQ-037 Negative weight, wsign[1]=1: neuron 1 sees 8 ones -> agg=-8 -> out_data=0, out_idx=1. Gaps in in_valid -> same results, stall only.
REQ-038 Backpressure: out_ready=0 for 5 cycles -> out_valid, out_data, out_idx held, in_ready=0, no bits consumed.
REQ-039 Saturation, agg_width=4, alu_width=4, win_len=10: all ones, wsign=0 -> out_data=7; wsign=1 -> out_data=0.
REQ-040 Full layer, n_neur=4: four results with out_idx 0..3, then done=1 for one cycle and busy=0. start mid-layer is ignored; abort in ACC -> IDLE next cycle with no done pulse.
